// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with one-deep request slots per master,
// a single outstanding bus transaction and a WAIT-state timeout.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m0_DV,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,

    input  logic        i_m1_DV,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,

    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic        o_m0_busy,
    output logic        o_m0_error,

    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic        o_m1_busy,
    output logic        o_m1_error,

    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    output logic [2:0]  o_bus_bhw,
    output logic        o_bus_write_notread,
    output logic        o_bus_DV,

    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,

    output logic        o_grant,
    output logic        o_bus_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0][31:0]  slot_addr_q, slot_addr_d;
    logic [1:0][31:0]  slot_data_q, slot_data_d;
    logic [1:0][2:0]   slot_bhw_q, slot_bhw_d;
    logic [1:0]        slot_wnr_q, slot_wnr_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_data_q, bus_data_d;
    logic [2:0]        bus_bhw_q, bus_bhw_d;
    logic              bus_wnr_q, bus_wnr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic              winner;

    // On a tie the master that was not granted last wins; otherwise the lone requester.
    assign winner = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        slot_bhw_d   = slot_bhw_q;
        slot_wnr_d   = slot_wnr_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        bus_bhw_d    = bus_bhw_q;
        bus_wnr_d    = bus_wnr_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    bus_addr_d   = slot_addr_q[winner];
                    bus_data_d   = slot_data_q[winner];
                    bus_bhw_d    = slot_bhw_q[winner];
                    bus_wnr_d    = slot_wnr_q[winner];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the very cycle the count hits the limit still counts as normal.
                if (i_bus_DV) begin
                    rdata_d[grant_q] = i_bus_data;
                    err_d[grant_q]   = 1'b0;
                    state_d          = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d[grant_q] = 32'hFFFF_FFFF;
                    err_d[grant_q]   = 1'b1;
                    state_d          = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                pend_d[grant_q] = 1'b0;
                state_d         = S_IDLE;
            end
        endcase

        if (i_m0_DV && !pend_q[0]) begin
            pend_d[0]      = 1'b1;
            slot_addr_d[0] = i_m0_address;
            slot_data_d[0] = i_m0_data;
            slot_bhw_d[0]  = i_m0_bhw;
            slot_wnr_d[0]  = i_m0_write_notread;
        end
        if (i_m1_DV && !pend_q[1]) begin
            pend_d[1]      = 1'b1;
            slot_addr_d[1] = i_m1_address;
            slot_data_d[1] = i_m1_data;
            slot_bhw_d[1]  = i_m1_bhw;
            slot_wnr_d[1]  = i_m1_write_notread;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            slot_bhw_q   <= '0;
            slot_wnr_q   <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_bhw_q    <= '0;
            bus_wnr_q    <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            slot_bhw_q   <= slot_bhw_d;
            slot_wnr_q   <= slot_wnr_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_bhw_q    <= bus_bhw_d;
            bus_wnr_q    <= bus_wnr_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign o_bus_address       = bus_addr_q;
    assign o_bus_data          = bus_data_q;
    assign o_bus_bhw           = bus_bhw_q;
    assign o_bus_write_notread = bus_wnr_q;
    assign o_bus_DV            = (state_q == S_ISSUE);
    assign o_bus_busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign o_grant             = grant_q;

    assign o_m0_DV    = (state_q == S_RESP) && (grant_q == 1'b0);
    assign o_m1_DV    = (state_q == S_RESP) && (grant_q == 1'b1);
    assign o_m0_busy  = pend_q[0];
    assign o_m1_busy  = pend_q[1];
    assign o_m0_data  = rdata_q[0];
    assign o_m1_data  = rdata_q[1];
    assign o_m0_error = err_q[0];
    assign o_m1_error = err_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level round-robin model.
module tb_bus_arbiter;

    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_m0_DV, i_m1_DV;
    logic [31:0] i_m0_address, i_m1_address, i_m0_data, i_m1_data;
    logic [2:0]  i_m0_bhw, i_m1_bhw;
    logic        i_m0_write_notread, i_m1_write_notread;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_DV, o_m1_DV, o_m0_busy, o_m1_busy, o_m0_error, o_m1_error;
    logic [31:0] o_bus_address, o_bus_data;
    logic [2:0]  o_bus_bhw;
    logic        o_bus_write_notread, o_bus_DV;
    logic [31:0] i_bus_data;
    logic        i_bus_DV;
    logic        o_grant, o_bus_busy;

    int checks = 0;
    int errors = 0;
    int lastGrant;

    logic [31:0] reqAddr [2];
    logic [31:0] reqData [2];
    logic [2:0]  reqBhw  [2];
    logic        reqWnr  [2];

    bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_DV(i_m0_DV), .i_m0_address(i_m0_address), .i_m0_data(i_m0_data),
        .i_m0_bhw(i_m0_bhw), .i_m0_write_notread(i_m0_write_notread),
        .i_m1_DV(i_m1_DV), .i_m1_address(i_m1_address), .i_m1_data(i_m1_data),
        .i_m1_bhw(i_m1_bhw), .i_m1_write_notread(i_m1_write_notread),
        .o_m0_data(o_m0_data), .o_m0_DV(o_m0_DV), .o_m0_busy(o_m0_busy), .o_m0_error(o_m0_error),
        .o_m1_data(o_m1_data), .o_m1_DV(o_m1_DV), .o_m1_busy(o_m1_busy), .o_m1_error(o_m1_error),
        .o_bus_address(o_bus_address), .o_bus_data(o_bus_data), .o_bus_bhw(o_bus_bhw),
        .o_bus_write_notread(o_bus_write_notread), .o_bus_DV(o_bus_DV),
        .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV),
        .o_grant(o_grant), .o_bus_busy(o_bus_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic mDv(input int m);
        return (m == 1) ? o_m1_DV : o_m0_DV;
    endfunction

    function automatic logic mBusy(input int m);
        return (m == 1) ? o_m1_busy : o_m0_busy;
    endfunction

    function automatic logic [31:0] mData(input int m);
        return (m == 1) ? o_m1_data : o_m0_data;
    endfunction

    function automatic logic mErr(input int m);
        return (m == 1) ? o_m1_error : o_m0_error;
    endfunction

    task automatic driveMaster(input int m, input logic dv, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] b, input logic w);
        if (m == 1) begin
            i_m1_DV = dv; i_m1_address = a; i_m1_data = d; i_m1_bhw = b; i_m1_write_notread = w;
        end else begin
            i_m0_DV = dv; i_m0_address = a; i_m0_data = d; i_m0_bhw = b; i_m0_write_notread = w;
        end
    endtask

    task automatic randomizeReq(input int m);
        reqAddr[m] = $urandom;
        reqData[m] = $urandom;
        reqBhw[m]  = 3'($urandom_range(0, 7));
        reqWnr[m]  = 1'($urandom_range(0, 1));
    endtask

    // Pulses the selected masters' request for one clock, starting at a falling edge.
    task automatic applyStimulus(input logic [1:0] mask);
        for (int m = 0; m < 2; m++)
            if (mask[m]) driveMaster(m, 1'b1, reqAddr[m], reqData[m], reqBhw[m], reqWnr[m]);
        @(negedge i_clk);
        i_m0_DV = 1'b0;
        i_m1_DV = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bus_dv"}, o_bus_DV, 0);
        checkOutput({tag, "_bus_busy"}, o_bus_busy, 0);
        checkOutput({tag, "_grant"}, o_grant, 0);
        checkOutput({tag, "_bus_addr"}, o_bus_address, 0);
        checkOutput({tag, "_bus_data"}, o_bus_data, 0);
        checkOutput({tag, "_bus_bhw"}, o_bus_bhw, 0);
        checkOutput({tag, "_bus_wnr"}, o_bus_write_notread, 0);
        checkOutput({tag, "_m0_dv"}, o_m0_DV, 0);
        checkOutput({tag, "_m1_dv"}, o_m1_DV, 0);
        checkOutput({tag, "_m0_busy"}, o_m0_busy, 0);
        checkOutput({tag, "_m1_busy"}, o_m1_busy, 0);
        checkOutput({tag, "_m0_err"}, o_m0_error, 0);
        checkOutput({tag, "_m1_err"}, o_m1_error, 0);
        checkOutput({tag, "_m0_data"}, o_m0_data, 0);
        checkOutput({tag, "_m1_data"}, o_m1_data, 0);
    endtask

    task automatic checkQuiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge i_clk);
            if (o_bus_DV || o_m0_DV || o_m1_DV) seen++;
        end
        checkOutput(tag, seen, 0);
    endtask

    // One bus transaction for master expM. The slave answers in WAIT cycle respIdx
    // (cycles counted from 0); an index beyond TMO means it never answers.
    // pulseM >= 0 pulses that master's request in the first WAIT cycle, and again
    // in the RESP cycle when it is the granted master.
    task automatic serviceTxn(input int expM, input int respIdx, input logic [31:0] respData, input int pulseM);
        int waited = 0;
        logic [31:0] expData;
        while (o_bus_DV !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        checkOutput("issue_seen", o_bus_DV, 1);
        if (o_bus_DV !== 1'b1) return;
        checkOutput("issue_bus_busy", o_bus_busy, 1);
        checkOutput("issue_grant", o_grant, expM);
        checkOutput("issue_addr", o_bus_address, reqAddr[expM]);
        checkOutput("issue_data", o_bus_data, reqData[expM]);
        checkOutput("issue_bhw", o_bus_bhw, reqBhw[expM]);
        checkOutput("issue_wnr", o_bus_write_notread, reqWnr[expM]);
        for (int w = 0; w <= TMO; w++) begin
            @(negedge i_clk);
            i_m0_DV = 1'b0;
            i_m1_DV = 1'b0;
            checkOutput("wait_bus_dv_low", o_bus_DV, 0);
            checkOutput("wait_addr_stable", o_bus_address, reqAddr[expM]);
            if (w == 0 && pulseM >= 0) begin
                if (pulseM != expM) begin
                    randomizeReq(pulseM);
                    driveMaster(pulseM, 1'b1, reqAddr[pulseM], reqData[pulseM], reqBhw[pulseM], reqWnr[pulseM]);
                end else begin
                    driveMaster(pulseM, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
                end
            end
            if (w == respIdx) begin
                i_bus_DV   = 1'b1;
                i_bus_data = respData;
                break;
            end
        end
        @(negedge i_clk);
        i_bus_DV = 1'b0;
        i_m0_DV  = 1'b0;
        i_m1_DV  = 1'b0;
        expData = (respIdx <= TMO) ? respData : 32'hFFFF_FFFF;
        checkOutput("resp_dv", mDv(expM), 1);
        checkOutput("resp_other_dv", mDv(1 - expM), 0);
        checkOutput("resp_data", mData(expM), expData);
        checkOutput("resp_err", mErr(expM), (respIdx > TMO) ? 1 : 0);
        checkOutput("resp_bus_busy", o_bus_busy, 0);
        checkOutput("resp_busy", mBusy(expM), 1);
        if (pulseM == expM)
            driveMaster(expM, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
        @(negedge i_clk);
        i_m0_DV = 1'b0;
        i_m1_DV = 1'b0;
        checkOutput("after_dv_low", mDv(expM), 0);
        checkOutput("after_busy_low", mBusy(expM), 0);
        checkOutput("after_data_held", mData(expM), expData);
    endtask

    initial begin
        logic [1:0] mask;
        int first, m, late, pulse, waited;

        i_rst = 1'b1;
        i_bus_DV = 1'b0;
        i_bus_data = '0;
        driveMaster(0, 1'b0, '0, '0, '0, 1'b0);
        driveMaster(1, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge i_clk);
        checkAllZero("rst");
        i_rst = 1'b0;
        lastGrant = 1;
        @(negedge i_clk);

        // A slave completion while idle must be ignored.
        i_bus_DV = 1'b1;
        i_bus_data = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_bus_DV = 1'b0;
        checkQuiet("idle_bus_dv_ignored", 3);

        // Simultaneous pair right after reset: master 0 first.
        randomizeReq(0);
        randomizeReq(1);
        applyStimulus(2'b11);
        checkOutput("pair1_busy0", o_m0_busy, 1);
        checkOutput("pair1_busy1", o_m1_busy, 1);
        first = 1 - lastGrant;
        checkOutput("pair1_first_is_m0", first, 0);
        serviceTxn(first, 1, $urandom, -1);
        serviceTxn(1 - first, 0, $urandom, -1);
        lastGrant = 1 - first;

        // Single read from master 0 with fixed fields; 2-cycle issue latency.
        reqAddr[0] = 32'h8000_0000;
        reqData[0] = 32'h0;
        reqBhw[0]  = 3'b010;
        reqWnr[0]  = 1'b0;
        applyStimulus(2'b01);
        checkOutput("single_busy_after_capture", o_m0_busy, 1);
        checkOutput("single_no_issue_yet", o_bus_DV, 0);
        @(negedge i_clk);
        checkOutput("single_issue_latency", o_bus_DV, 1);
        serviceTxn(0, 2, 32'h1234_5678, -1);
        lastGrant = 0;
        checkOutput("single_m1_idle", o_m1_busy, 0);

        // Second simultaneous pair: master 0 was granted last, so master 1 wins.
        randomizeReq(0);
        randomizeReq(1);
        applyStimulus(2'b11);
        first = 1 - lastGrant;
        checkOutput("pair2_first_is_m1", first, 1);
        serviceTxn(first, 3, $urandom, -1);
        serviceTxn(1 - first, 2, $urandom, -1);
        lastGrant = 1 - first;

        // Timeout on master 1, then a normal completion clears the error.
        randomizeReq(1);
        applyStimulus(2'b10);
        serviceTxn(1, TMO + 10, 32'h0, -1);
        lastGrant = 1;
        randomizeReq(1);
        applyStimulus(2'b10);
        serviceTxn(1, 1, $urandom, -1);

        // Completion on the exact cycle the count reaches the limit.
        randomizeReq(1);
        applyStimulus(2'b10);
        serviceTxn(1, TMO, 32'hA5A5_A5A5, -1);

        // Re-request while busy is dropped: exactly one bus transaction.
        randomizeReq(0);
        applyStimulus(2'b01);
        serviceTxn(0, 3, $urandom, 0);
        lastGrant = 0;
        checkQuiet("busy_drop_single_txn", 6);

        // Randomized rounds against the round-robin model.
        for (int r = 0; r < 40; r++) begin
            mask = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++)
                if (mask[k]) randomizeReq(k);
            applyStimulus(mask);
            if (mask == 2'b11) begin
                first = 1 - lastGrant;
                serviceTxn(first, $urandom_range(0, TMO + 2), $urandom, -1);
                serviceTxn(1 - first, $urandom_range(0, TMO + 2), $urandom, -1);
                lastGrant = 1 - first;
            end else begin
                m = (mask == 2'b10) ? 1 : 0;
                late = $urandom_range(0, 1);
                pulse = late ? (1 - m) : ($urandom_range(0, 1) ? m : -1);
                serviceTxn(m, $urandom_range(0, TMO + 2), $urandom, pulse);
                lastGrant = m;
                if (pulse == 1 - m) begin
                    serviceTxn(1 - m, $urandom_range(0, TMO + 2), $urandom, -1);
                    lastGrant = 1 - m;
                end else if (pulse == m) begin
                    checkQuiet("rand_busy_drop_quiet", 3);
                end
            end
        end

        // Reset in the middle of WAIT, then a late slave completion.
        randomizeReq(0);
        applyStimulus(2'b01);
        waited = 0;
        while (o_bus_DV !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        checkOutput("midrst_issue_seen", o_bus_DV, 1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checkAllZero("midrst");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_bus_DV = 1'b1;
        i_bus_data = $urandom;
        @(negedge i_clk);
        i_bus_DV = 1'b0;
        checkQuiet("midrst_no_completion", 8);
        checkOutput("midrst_m0_busy", o_m0_busy, 0);
        checkOutput("midrst_m1_busy", o_m1_busy, 0);
        checkOutput("midrst_bus_busy", o_bus_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
